// File: rtl/pterm_array_if.sv
// pterm_array_if: serial fuse-load handshake and status between a configuration master and pterm_array
interface pterm_array_if;
    logic cfg_start;
    logic cfg_valid;
    logic cfg_bit;
    logic cfg_ready;
    logic cfg_dout;
    logic armed;

    modport master (output cfg_start, cfg_valid, cfg_bit, input cfg_ready, cfg_dout, armed);
    modport slave  (input cfg_start, cfg_valid, cfg_bit, output cfg_ready, cfg_dout, armed);
endinterface

// File: rtl/pterm_array.sv
// pterm_array: serially fuse-programmed product-term AND array with registered outputs
// Optional fuse readback on cfg_dout is enabled by defining PTERM_ARRAY_READBACK_EN.
module pterm_array #(
    parameter int NUM_FLB = 16,
    parameter int NUM_UIM = 40,
    parameter int NUM_PT  = 5
) (
    input  logic               clk,
    input  logic               rst,
    pterm_array_if.slave       cfg,
    input  logic [NUM_FLB-1:0] mc_flb,
    input  logic [NUM_UIM-1:0] uim_p,
    output logic [NUM_PT-1:0]  pt
);
    localparam int W  = NUM_FLB + 2 * NUM_UIM;
    localparam int F  = NUM_PT * W;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

    state_t state, next;
    logic [CW-1:0] cnt;
    logic [F-1:0] fuses;
    logic [W-1:0] vec;
    logic [NUM_PT-1:0] rows;
    logic xfer, last;

    assign cfg.cfg_ready = state == LOAD;
    assign cfg.armed = state == ARMED;
    // A start pulse wins over a coincident transfer, which is then dropped.
    assign xfer = cfg.cfg_valid && cfg.cfg_ready && !cfg.cfg_start;
    assign last = xfer && cnt == CW'(F - 1);

    // Next-state: start always (re)enters LOAD; the final transfer arms the array.
    always_comb begin
        next = state;
        if (cfg.cfg_start)
            next = LOAD;
        else if (last)
            next = ARMED;
    end

    // State register.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= next;

    // Transfer counter, wraps to 0 when the map is complete.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (cfg.cfg_start)
            cnt <= '0;
        else if (xfer)
            cnt <= last ? '0 : cnt + 1'b1;

    // Fuse chain shifts toward index 0 so the first bit sent lands at index 0.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            fuses <= '0;
        else if (xfer)
            fuses <= {cfg.cfg_bit, fuses[F-1:1]};

    for (genvar c = 0; c < NUM_FLB; c++) begin : g_flb
        assign vec[c] = mc_flb[c];
    end
    for (genvar i = 0; i < NUM_UIM; i++) begin : g_uim
        assign vec[NUM_FLB + 2*i]     = uim_p[i];
        assign vec[NUM_FLB + 2*i + 1] = ~uim_p[i];
    end

    // A set fuse forces its term input to 1, so each row ANDs only connected inputs.
    always_comb begin
        rows = '0;
        for (int r = 0; r < NUM_PT; r++)
            rows[r] = &(fuses[r*W +: W] | vec);
    end

    // Product terms register only while armed and not being restarted.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            pt <= '0;
        else
            pt <= (state == ARMED && !cfg.cfg_start) ? rows : '0;

`ifdef PTERM_ARRAY_READBACK_EN
    // The fuse leaving the chain emerges on cfg_dout, so a reload reads the old map in order.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cfg.cfg_dout <= 1'b0;
        else if (xfer)
            cfg.cfg_dout <= fuses[0];
`else
    assign cfg.cfg_dout = 1'b0;
`endif
endmodule

// File: tb/tb_pterm_array.sv
// tb_pterm_array: directed self-checking bench for pterm_array (default parameters, W=96, F=480)
module tb_pterm_array;
    logic clk = 0;
    logic rst = 1;
    logic [15:0] mc_flb = '0;
    logic [39:0] uim_p = '0;
    logic [4:0] pt;
    int passed = 0;
    int total = 0;

    pterm_array_if bus ();

    pterm_array dut (.clk(clk), .rst(rst), .cfg(bus.slave), .mc_flb(mc_flb), .uim_p(uim_p), .pt(pt));

    always #5 clk = ~clk;

    // Fuse patterns: 0 all ones, 1 row0 col16 cleared, 2 row1 col16/17 cleared, 3 bit n = n mod 2, 4 all zeros
    function automatic logic pat(int m, int i);
        case (m)
            0: return 1'b1;
            1: return i != 16;
            2: return !(i == 112 || i == 113);
            3: return logic'(i % 2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [4:0] got, logic [4:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %b expected %b", name, got, exp);
        else passed++;
    endtask

    task automatic start_pulse();
        @(negedge clk) bus.cfg_start = 1;
        @(negedge clk) bus.cfg_start = 0;
    endtask

    // Sends n bits of pattern m; rbm >= 0 checks cfg_dout against the old map pattern rbm.
    task automatic send(string name, int n, int m, int rbm, logic arm_end);
        int early = 0, ptbad = 0, rbbad = 0;
        logic exp_rb;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.armed !== 1'b0) early++;
            if (pt !== 5'b0) ptbad++;
            bus.cfg_valid = 1;
            bus.cfg_bit = pat(m, i);
            @(posedge clk);
            #1;
`ifdef PTERM_ARRAY_READBACK_EN
            exp_rb = pat(rbm, i);
`else
            exp_rb = 1'b0;
`endif
            if (rbm >= 0 && bus.cfg_dout !== exp_rb) rbbad++;
        end
        @(negedge clk) bus.cfg_valid = 0;
        total++;
        if (early !== 0) $display("FAIL %s_armed_early: got %0d early cycles expected 0", name, early);
        else passed++;
        total++;
        if (ptbad !== 0) $display("FAIL %s_pt_during_load: got %0d nonzero cycles expected 0", name, ptbad);
        else passed++;
        if (rbm >= 0) begin
            total++;
            if (rbbad !== 0) $display("FAIL %s_readback: got %0d wrong bits expected 0", name, rbbad);
            else passed++;
        end
        chk({name, "_armed_end"}, {4'b0, bus.armed}, {4'b0, arm_end});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk("reset_armed", {4'b0, bus.armed}, 5'b0);
        chk("reset_ready", {4'b0, bus.cfg_ready}, 5'b0);
        chk("reset_pt", pt, 5'b0);
        chk("reset_dout", {4'b0, bus.cfg_dout}, 5'b0);
        rst = 0;
        @(negedge clk);
        chk("idle_ready", {4'b0, bus.cfg_ready}, 5'b0);
    endtask

    task automatic test_all_ones();
        start_pulse();
        chk("load_ready", {4'b0, bus.cfg_ready}, 5'b1);
        send("ones", 480, 0, 4, 1'b1);
        chk("ones_pt_arm_edge", pt, 5'b0);
        mc_flb = 16'hA5C3;
        uim_p = 40'h12_3456_789A;
        @(negedge clk);
        chk("ones_pt_a", pt, 5'b11111);
        mc_flb = '0;
        uim_p = '0;
        @(negedge clk);
        chk("ones_pt_b", pt, 5'b11111);
    endtask

    task automatic test_valid_ignored();
        bus.cfg_valid = 1;
        bus.cfg_bit = 0;
        repeat (10) @(negedge clk);
        bus.cfg_valid = 0;
        chk("ignored_ready", {4'b0, bus.cfg_ready}, 5'b0);
        @(negedge clk);
        chk("ignored_pt", pt, 5'b11111);
    endtask

    task automatic test_row0();
        start_pulse();
        chk("row0_restart_pt", pt, 5'b0);
        send("row0", 480, 1, 0, 1'b1);
        uim_p = 40'h1;
        @(negedge clk);
        chk("row0_uim1", pt, 5'b11111);
        uim_p = 40'h0;
        @(negedge clk);
        chk("row0_uim0", pt, 5'b11110);
    endtask

    task automatic test_row1();
        start_pulse();
        send("row1", 480, 2, 1, 1'b1);
        uim_p = 40'h1;
        @(negedge clk);
        chk("row1_uim1", pt, 5'b11101);
        uim_p = 40'h0;
        @(negedge clk);
        chk("row1_uim0", pt, 5'b11101);
    endtask

    task automatic test_restart();
        start_pulse();
        send("part200", 200, 0, 2, 1'b0);
        start_pulse();
        send("after_restart", 480, 0, -1, 1'b1);
        @(negedge clk);
        chk("restart_pt", pt, 5'b11111);
    endtask

    task automatic test_coincident();
        start_pulse();
        send("pre5", 5, 0, -1, 1'b0);
        @(negedge clk);
        bus.cfg_start = 1;
        bus.cfg_valid = 1;
        bus.cfg_bit = 0;
        @(negedge clk);
        bus.cfg_start = 0;
        bus.cfg_valid = 0;
        send("coincident", 479, 0, -1, 1'b0);
        send("coincident_last", 1, 0, -1, 1'b1);
    endtask

    task automatic test_reset_midload();
        start_pulse();
        send("mid300", 300, 1, -1, 1'b0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_armed", {4'b0, bus.armed}, 5'b0);
        chk("midrst_ready", {4'b0, bus.cfg_ready}, 5'b0);
        chk("midrst_pt", pt, 5'b0);
        @(negedge clk);
        rst = 0;
        bus.cfg_valid = 1;
        repeat (3) @(negedge clk);
        bus.cfg_valid = 0;
        chk("midrst_idle_ready", {4'b0, bus.cfg_ready}, 5'b0);
        start_pulse();
        send("after_rst", 480, 3, 4, 1'b1);
        @(negedge clk);
        chk("alt_pt", pt, 5'b0);
    endtask

    task automatic test_readback();
        start_pulse();
        send("reload_alt", 480, 0, 3, 1'b1);
    endtask

    initial begin
        bus.cfg_start = 0;
        bus.cfg_valid = 0;
        bus.cfg_bit = 0;
        test_reset();
        test_all_ones();
        test_valid_ignored();
        test_row0();
        test_row1();
        test_restart();
        test_coincident();
        test_reset_midload();
        test_readback();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
